// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding comparator for one E-stage source register.
// The younger result in M wins over W, and x0 is never forwarded.
module forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_sel
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(REG_ZERO);

  // forwarding source select, M before W
  always_comb begin
    fwd_sel = FWD_RF;
    if (regwrite_m && (rd_m != X0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != X0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with a memory-wait FSM.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  memtoreg_e,
  input  logic                  pcsrc_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  mem_req_m,
  input  logic                  mem_ready,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  mem_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam logic [REG_ADDR_W-1:0] X0        = REG_ADDR_W'(REG_ZERO);
  localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  hz_state_t        state_r, state_next_s;
  logic [TMO_W-1:0] cnt_r, cnt_next_s;
  logic             timeout_s;
  logic             mem_stall_s;
  logic             load_use_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  // state and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // next-state and timeout detection
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    timeout_s    = 1'b0;
    case (state_r)
      RUN: begin
        cnt_next_s = '0;
        if (mem_req_m && !mem_ready) begin
          state_next_s = MEM_WAIT;
        end else begin
          state_next_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next_s = RUN;
          cnt_next_s   = '0;
        end else if (cnt_r == TMO_LIMIT) begin
          timeout_s    = 1'b1;
          state_next_s = RUN;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s   = cnt_r + TMO_W'(1);
        end
      end
      default: begin
        state_next_s = RUN;
        cnt_next_s   = '0;
      end
    endcase
  end

  // the entry cycle already stalls, before the FSM has left RUN
  assign mem_stall_s = (state_r == MEM_WAIT) ? !mem_ready : (mem_req_m && !mem_ready);
  assign load_use_s  = memtoreg_e && (rd_e != X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // stall/flush priority: reset > memory wait > branch > load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pcsrc_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  assign mem_error = timeout_s && !reset;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e       (rs1_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd_sel    (fwd_a_s)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e       (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd_sel    (fwd_b_s)
  );

  assign fwd_a_e = reset ? 2'b00 : fwd_a_s;
  assign fwd_b_e = reset ? 2'b00 : fwd_b_s;

`ifdef HAZARD_PERF_EN
  // saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (stall_f && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((flush_d || flush_e) && (flush_events != 32'hFFFF_FFFF)) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule
